wb_regbank_semver: RTL

WB_REGBANK_SEMVER -- requirements
Module: wb_regbank_semver

---
 rtl/wb_regbank_semver.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/wb_regbank_semver.sv
// Wishbone pipelined register bank with read-only semantic version word.
// Word 0 holds the version, words 1..NREGS are byte-writable registers.
module wb_regbank_semver #(
  parameter int NREGS = 4,
  parameter int PIPE = 1,
  parameter logic [7:0] VER_MAJOR = 8'd1,
  parameter logic [7:0] VER_MINOR = 8'd2,
  parameter logic [7:0] VER_PATCH = 8'd3,
  parameter logic [NREGS*32-1:0] RST_VALS = '0,
  localparam int ADDR_W = (NREGS < 1) ? 1 : $clog2(NREGS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_W+1:2]     wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic                  wb_stall_o,
  output logic [NREGS*32-1:0]   regs_o,
  output logic [NREGS-1:0]      wr_strobe_o
);

  localparam logic [ADDR_W-1:0] NR = ADDR_W'(NREGS);

  logic              wb_en;
  logic              busy_q;
  logic              accept;
  logic              racc;
  logic              wacc;
  logic              r_ok;
  logic              ack_q;
  logic              err_q;
  logic [31:0]       dat_q;
  logic [31:0]       rdata;
  logic [NREGS-1:0]  stb_q;
  logic [31:0]       regs_q [NREGS];

  logic              c_vld;
  logic [ADDR_W-1:0] c_adr;
  logic [31:0]       c_dat;
  logic [3:0]        c_sel;
  logic              c_ok;

  // One outstanding transfer: busy covers accept through the response cycle
  assign wb_en  = wb_cyc_i & wb_stb_i;
  assign accept = wb_en & ~busy_q;
  assign racc   = accept & ~wb_we_i;
  assign wacc   = accept & wb_we_i;
  assign r_ok   = wb_adr_i <= NR;
  assign c_ok   = c_adr <= NR;

  generate
    if (PIPE != 0) begin : g_pipe
      logic              w_vld;
      logic [ADDR_W-1:0] w_adr;
      logic [31:0]       w_dat;
      logic [3:0]        w_sel;

      // Register the accepted write so the commit happens one cycle later
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          w_vld <= 1'b0;
          w_adr <= '0;
          w_dat <= '0;
          w_sel <= '0;
        end else begin
          w_vld <= wacc;
          if (wacc) begin
            w_adr <= wb_adr_i;
            w_dat <= wb_dat_i;
            w_sel <= wb_sel_i;
          end
        end
      end

      assign c_vld = w_vld;
      assign c_adr = w_adr;
      assign c_dat = w_dat;
      assign c_sel = w_sel;
    end else begin : g_direct
      assign c_vld = wacc;
      assign c_adr = wb_adr_i;
      assign c_dat = wb_dat_i;
      assign c_sel = wb_sel_i;
    end
  endgenerate

  // Read mux: version word, mapped registers, zero for unmapped
  always_comb begin
    rdata = '0;
    if (wb_adr_i == '0) begin
      rdata = {8'h00, VER_MAJOR, VER_MINOR, VER_PATCH};
    end
    for (int k = 0; k < NREGS; k++) begin
      if (wb_adr_i == ADDR_W'(k + 1)) begin
        rdata = regs_q[k];
      end
    end
  end

  // Bus response: busy flag, ack/err pulses, read data and write strobes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dat_q  <= '0;
      stb_q  <= '0;
    end else begin
      if (ack_q | err_q) begin
        busy_q <= 1'b0;
      end else if (accept) begin
        busy_q <= 1'b1;
      end
      ack_q <= (racc & r_ok) | (c_vld & c_ok);
      err_q <= (racc & ~r_ok) | (c_vld & ~c_ok);
      dat_q <= (racc & r_ok) ? rdata : '0;
      for (int k = 0; k < NREGS; k++) begin
        stb_q[k] <= wacc && (wb_adr_i == ADDR_W'(k + 1));
      end
    end
  end

  // Register file: byte-lane commit from the write commit stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= RST_VALS[32*k +: 32];
      end
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        if (c_vld && (c_adr == ADDR_W'(k + 1))) begin
          for (int b = 0; b < 4; b++) begin
            if (c_sel[b]) begin
              regs_q[k][8*b +: 8] <= c_dat[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Flatten register contents onto the output bus
  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NREGS; k++) begin
      regs_o[32*k +: 32] = regs_q[k];
    end
  end

  assign wb_dat_o    = dat_q;
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign wb_rty_o    = 1'b0;
  assign wb_stall_o  = wb_en & ~(ack_q | err_q);
  assign wr_strobe_o = stb_q;

endmodule
